sipo_deframer: RTL and testbench

SIPO_DEFRAMER -- requirements
Module: sipo_deframer

---
 rtl/sipo_deframer_pkg.sv | 21 ++
 rtl/sipo_deframer_if.sv | 45 ++++
 rtl/sipo_deframer_outreg.sv | 65 ++++++
 rtl/sipo_deframer.sv | 144 ++++++++++++++
 tb/tb_sipo_deframer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_deframer_pkg.sv
// ============================================================================
//  Module      : sipo_pkg
//  Description : Shared FSM state encoding and default word width for the
//                serial-to-parallel deframer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sipo_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sipo_deframer_if.sv
// ============================================================================
//  Module      : sipo_deframer_if
//  Description : Serial input / parallel output bundle of the deframer.
//                par_err exists only when SIPO_DEFRAMER_PARITY_CHECK_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sipo_deframer_if #(
    parameter int WIDTH = sipo_pkg::c_default_width
) ();

    logic             sin;
    logic             shift;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
    logic             par_err;
`endif

    // Driven by the bit source / word consumer.
    modport master (
        output sin, shift, start, dout_ready,
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
        input  par_err,
`endif
        input  dout, dout_valid, busy, overrun
    );

    // Implemented by the deframer.
    modport slave (
        input  sin, shift, start, dout_ready,
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
        output par_err,
`endif
        output dout, dout_valid, busy, overrun
    );

endinterface

`default_nettype wire

// File: rtl/sipo_deframer_outreg.sv
// ============================================================================
//  Module      : sipo_outreg
//  Description : One-entry output register with valid/ready handshake and
//                overrun pulse when a completed word finds the register full.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_outreg
    import sipo_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic             overrun_o,
    output logic             load_o
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             w_load;

    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        // A draining handshake in the same cycle frees the slot, so refill without a bubble.
        w_load    = load_req_i & (~valid_q | ready_i);
        if (w_load) begin
            dout_d  = data_i;
            valid_d = 1'b1;
        end else if (load_req_i) begin
            overrun_d = 1'b1;
        end else if (valid_q & ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout_o    = dout_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign load_o    = w_load;

endmodule

`default_nettype wire

// File: rtl/sipo_deframer.sv
// ============================================================================
//  Module      : sipo_deframer
//  Description : Collects MSB-first serial bits into WIDTH-bit words.
//                Define SIPO_DEFRAMER_PARITY_CHECK_EN for a trailing even
//                parity bit per word and the par_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic           clk,
    input  logic           rst,
    sipo_deframer_if.slave bus
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;

    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_word;
    logic               w_done;
    logic               w_load;
    logic [WIDTH-1:0]   w_dout;
    logic               w_valid;
    logic               w_overrun;
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
    logic               w_perr;
    logic               par_err_q;
`else
    logic               w_unused_load;
`endif

    assign w_shifted = {sreg_q[WIDTH-2:0], bus.sin};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        w_done  = 1'b0;
        w_word  = w_shifted;
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
        w_perr  = 1'b0;
`endif
        if (bus.start) begin
            // start wins in every state; a partial word is simply abandoned.
            state_d = SHIFT;
            cnt_d   = '0;
            if (bus.shift) begin
                sreg_d = w_shifted;
                cnt_d  = c_one;
            end
        end else begin
            case (state_q)
                SHIFT: begin
                    if (bus.shift) begin
                        sreg_d = w_shifted;
                        if (cnt_q == c_last) begin
                            cnt_d   = '0;
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
                            state_d = PARITY;
`else
                            state_d = IDLE;
                            w_done  = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + c_one;
                        end
                    end
                end
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
                PARITY: begin
                    // Parity bit is not shifted in; the data word is already complete.
                    if (bus.shift) begin
                        state_d = IDLE;
                        w_done  = 1'b1;
                        w_word  = sreg_q;
                        w_perr  = ^{sreg_q, bus.sin};
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end

    sipo_outreg #(
        .WIDTH (WIDTH)
    ) u_outreg (
        .clk        (clk),
        .rst        (rst),
        .load_req_i (w_done),
        .data_i     (w_word),
        .ready_i    (bus.dout_ready),
        .dout_o     (w_dout),
        .valid_o    (w_valid),
        .overrun_o  (w_overrun),
        .load_o     (w_load)
    );

`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
    // Flag only words that actually reach dout, so it lines up with the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= w_load & w_perr;
        end
    end

    assign bus.par_err = par_err_q;
`else
    assign w_unused_load = w_load;
`endif

    assign bus.dout       = w_dout;
    assign bus.dout_valid = w_valid;
    assign bus.overrun    = w_overrun;
    assign bus.busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sipo_deframer.sv
// ============================================================================
//  Module      : tb_sipo_deframer
//  Description : Directed bench for sipo_deframer with a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_deframer;

    localparam int WIDTH = 4;
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
    localparam int c_par = 1;
`else
    localparam int c_par = 0;
`endif
    localparam int c_frame_len = WIDTH + c_par;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sipo_deframer_if #(.WIDTH(WIDTH)) bus ();

    sipo_deframer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect bits of the current frame, form the word when the
    // frame is long enough, then apply the one-slot output buffer rules.
    bit             m_in_frame = 1'b0;
    bit             m_bits[$];
    logic [WIDTH-1:0] m_dout  = '0;
    bit             m_valid = 1'b0;
    bit             m_ovr   = 1'b0;
    bit             m_perr  = 1'b0;
    bit             m_done;
    bit             m_bad;
    logic [WIDTH-1:0] m_word;
    int             m_ones;

    always @(posedge clk) begin
        if (rst) begin
            m_in_frame = 1'b0;
            m_bits.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_perr  = 1'b0;
        end else begin
            m_done = 1'b0;
            m_ovr  = 1'b0;
            m_perr = 1'b0;
            if (bus.start) begin
                m_in_frame = 1'b1;
                m_bits.delete();
                if (bus.shift) m_bits.push_back(bus.sin);
            end else if (m_in_frame && bus.shift) begin
                m_bits.push_back(bus.sin);
                if (m_bits.size() == c_frame_len) begin
                    m_word = '0;
                    m_ones = 0;
                    for (int i = 0; i < WIDTH; i++) m_word = (m_word << 1) | WIDTH'(m_bits[i]);
                    for (int i = 0; i < c_frame_len; i++) m_ones += int'(m_bits[i]);
                    m_bad      = (c_par == 1) && (m_ones % 2 != 0);
                    m_done     = 1'b1;
                    m_in_frame = 1'b0;
                    m_bits.delete();
                end
            end
            if (m_done) begin
                if (!m_valid || bus.dout_ready) begin
                    m_dout  = m_word;
                    m_valid = 1'b1;
                    m_perr  = m_bad;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && bus.dout_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        chk("cyc_dout",       32'(bus.dout),       32'(m_dout));
        chk("cyc_dout_valid", 32'(bus.dout_valid), 32'(m_valid));
        chk("cyc_busy",       32'(bus.busy),       32'(m_in_frame));
        chk("cyc_overrun",    32'(bus.overrun),    32'(m_ovr));
`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
        chk("cyc_par_err",    32'(bus.par_err),    32'(m_perr));
`endif
    end

    task automatic drv(input bit st, input bit sh, input bit d, input bit rdy);
        @(negedge clk);
        bus.start      = st;
        bus.shift      = sh;
        bus.sin        = d;
        bus.dout_ready = rdy;
    endtask

    task automatic idle(input bit rdy);
        drv(1'b0, 1'b0, 1'b0, rdy);
    endtask

    // par_bit < 0 sends the correct even-parity bit; ready is only raised in the
    // frame's completion cycle.
    task automatic send(input logic [WIDTH-1:0] w, input bit use_start, input int par_bit,
                        input bit rdy_last);
        for (int i = 0; i < WIDTH; i++) begin
            bit last;
            last = (c_par == 0) && (i == WIDTH - 1);
            drv(use_start && (i == 0), 1'b1, w[WIDTH-1-i], last ? rdy_last : 1'b0);
        end
        if (c_par == 1) begin
            drv(1'b0, 1'b1, (par_bit < 0) ? ^w : par_bit[0], rdy_last);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.shift      = 1'b0;
        bus.sin        = 1'b0;
        bus.dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout",    32'(bus.dout),       32'h0);
        chk("rst_valid",   32'(bus.dout_valid), 32'h0);
        chk("rst_busy",    32'(bus.busy),       32'h0);
        chk("rst_overrun", 32'(bus.overrun),    32'h0);
        rst = 1'b0;

        // Word 0xB, valid one cycle after its last bit.
        send(4'hB, 1'b1, -1, 1'b0);
        idle(1'b0);
        chk("b_dout",  32'(bus.dout),       32'hB);
        chk("b_valid", 32'(bus.dout_valid), 32'h1);
        chk("b_busy",  32'(bus.busy),       32'h0);

        // Second word with the register full: dropped, overrun pulses once.
        send(4'h5, 1'b1, -1, 1'b0);
        idle(1'b0);
        chk("ovr_pulse", 32'(bus.overrun), 32'h1);
        chk("ovr_hold",  32'(bus.dout),    32'hB);
        idle(1'b0);
        chk("ovr_clear", 32'(bus.overrun), 32'h0);

        // Drain and refill in the same completion cycle.
        send(4'h5, 1'b1, -1, 1'b1);
        idle(1'b0);
        chk("refill_dout",  32'(bus.dout),       32'h5);
        chk("refill_valid", 32'(bus.dout_valid), 32'h1);
        chk("refill_ovr",   32'(bus.overrun),    32'h0);
        idle(1'b1);
        idle(1'b0);
        chk("drain_valid", 32'(bus.dout_valid), 32'h0);

        // Shifts without start in IDLE are ignored.
        repeat (3) drv(1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("ign_busy",  32'(bus.busy),       32'h0);
        chk("ign_valid", 32'(bus.dout_valid), 32'h0);

        // Restart after two bits abandons the partial word.
        drv(1'b1, 1'b1, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b1, 1'b0);
        send(4'h6, 1'b1, -1, 1'b0);
        idle(1'b0);
        chk("restart_dout",  32'(bus.dout),       32'h6);
        chk("restart_valid", 32'(bus.dout_valid), 32'h1);
        idle(1'b1);

        // start without shift, then gapped strobes.
        drv(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("gap_busy", 32'(bus.busy), 32'h1);
        send(4'hA, 1'b0, -1, 1'b0);
        idle(1'b0);
        chk("gap_dout", 32'(bus.dout), 32'hA);
        idle(1'b1);

        // Reset in the middle of a frame, then one more shift.
        drv(1'b1, 1'b1, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        bus.shift = 1'b1;
        bus.sin   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drv(1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("mrst_valid", 32'(bus.dout_valid), 32'h0);
        chk("mrst_busy",  32'(bus.busy),       32'h0);
        chk("mrst_dout",  32'(bus.dout),       32'h0);
        chk("mrst_ovr",   32'(bus.overrun),    32'h0);

`ifdef SIPO_DEFRAMER_PARITY_CHECK_EN
        send(4'hB, 1'b1, 0, 1'b0);
        idle(1'b0);
        chk("par_bad_dout", 32'(bus.dout),    32'hB);
        chk("par_bad_err",  32'(bus.par_err), 32'h1);
        idle(1'b1);
        send(4'hB, 1'b1, 1, 1'b0);
        idle(1'b0);
        chk("par_ok_dout", 32'(bus.dout),       32'hB);
        chk("par_ok_vld",  32'(bus.dout_valid), 32'h1);
        chk("par_ok_err",  32'(bus.par_err),    32'h0);
        idle(1'b1);
`endif

        // Back-to-back frames with a free consumer.
        send(4'h9, 1'b1, -1, 1'b1);
        send(4'h3, 1'b1, -1, 1'b1);
        idle(1'b0);
        chk("b2b_dout", 32'(bus.dout), 32'h3);

        repeat (3) idle(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
